arp_vlg_tx_ctl: RTL and testbench

- Scheduler that sits directly upstream of the ARP transmitter. It decides what ARP frame is sent next and drives the transmitter's send/hdr/done/busy handshake.
- Queues replies to incoming ARP requests that target the local IPv4 address.
- Issues ARP requests for address-resolution demands from the ARP table, with timed retries.
- Replies take priority over requests.

---
 rtl/arp_vlg_tx_ctl_pkg.sv | 60 ++++++
 rtl/arp_vlg_tx_ctl_if.sv | 12 +
 rtl/arp_vlg_reply_fifo.sv | 45 ++++
 rtl/arp_vlg_tx_ctl.sv | 171 +++++++++++++++++
 tb/tb_arp_vlg_tx_ctl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arp_vlg_tx_ctl_pkg.sv
// Shared ARP types, constants and header builders for the transmit scheduler.
// Device and header layouts match the ones the rest of the ARP block uses.
package arp_vlg_tx_ctl_pkg;

  typedef struct packed {
    logic [47:0] mac_addr;
    logic [31:0] ipv4_addr;
  } dev_t;

  typedef struct packed {
    logic [15:0] oper;
    logic [15:0] proto;
    logic [47:0] src_mac;
    logic [31:0] src_ipv4_addr;
    logic [47:0] dst_mac;
    logic [31:0] dst_ipv4_addr;
  } arp_hdr_t;

  typedef struct packed {
    logic [47:0] mac_addr;
    logic [31:0] ipv4_addr;
  } arp_reply_entry_t;

  localparam logic [15:0] OPER_REQ       = 16'd1;
  localparam logic [15:0] OPER_REP       = 16'd2;
  localparam logic [15:0] ARP_PROTO_IPV4 = 16'h0800;
  localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } tx_state_e;

  function automatic arp_hdr_t make_reply_hdr(dev_t dev, arp_reply_entry_t ent);
    arp_hdr_t h;
    h               = '0;
    h.oper          = OPER_REP;
    h.proto         = ARP_PROTO_IPV4;
    h.src_mac       = dev.mac_addr;
    h.src_ipv4_addr = dev.ipv4_addr;
    h.dst_mac       = ent.mac_addr;
    h.dst_ipv4_addr = ent.ipv4_addr;
    return h;
  endfunction

  function automatic arp_hdr_t make_request_hdr(dev_t dev, logic [31:0] ipv4);
    arp_hdr_t h;
    h               = '0;
    h.oper          = OPER_REQ;
    h.proto         = ARP_PROTO_IPV4;
    h.src_mac       = dev.mac_addr;
    h.src_ipv4_addr = dev.ipv4_addr;
    h.dst_mac       = BCAST_MAC;
    h.dst_ipv4_addr = ipv4;
    return h;
  endfunction

endpackage

// File: rtl/arp_vlg_tx_ctl_if.sv
// Handshake between the ARP scheduler (master) and the ARP transmitter (slave).
interface arp_vlg_tx_ctl_if
  import arp_vlg_tx_ctl_pkg::*;
();
  logic     send;
  arp_hdr_t hdr;
  logic     done;
  logic     busy;

  modport master (output send, output hdr, input done, input busy);
  modport slave  (input send, input hdr, output done, output busy);
endinterface

// File: rtl/arp_vlg_reply_fifo.sv
// Show-ahead FIFO of pending ARP replies; rdata is valid whenever empty is low.
module arp_vlg_reply_fifo
  import arp_vlg_tx_ctl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  arp_reply_entry_t wdata,
  input  logic             pop,
  output arp_reply_entry_t rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  arp_reply_entry_t mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A push into a full FIFO is still taken when a pop frees a slot the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/arp_vlg_tx_ctl.sv
// ARP transmit scheduler: queues replies for local-address requests and issues
// timed, retried ARP requests for the table; replies always go first.
//
// state | meaning
// IDLE  | choose next frame: queued reply, else pending request
// SEND  | one-cycle send strobe, hdr already loaded
// WAIT  | frame in flight, wait for done
// GAP   | wait for done and busy to drop before the next frame
module arp_vlg_tx_ctl
  import arp_vlg_tx_ctl_pkg::*;
#(
  parameter int VERBOSE     = 1,
  parameter     DUT_STRING  = "",
  parameter int FIFO_DEPTH  = 4,
  parameter int RETRY_TICKS = 1250000,
  parameter int RETRIES     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  dev_t                dev,
  input  logic                rx_val,
  input  arp_hdr_t            rx_hdr,
  input  logic                res_req,
  input  logic [31:0]         res_ipv4,
  input  logic                res_ok,
  arp_vlg_tx_ctl_if.master    tx,
  output logic                res_busy,
  output logic                res_fail,
  output logic                ovfl
);
  localparam int TW = $clog2(RETRY_TICKS + 1);
  localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(RETRY_TICKS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);

  tx_state_e        state_q, state_d;
  arp_hdr_t         hdr_q, hdr_d;
  logic             frame_req_q, frame_req_d;
  logic             pop, take_req, timer_start;
  logic             push_req, fifo_full, fifo_empty;
  arp_reply_entry_t rx_entry, head;

  logic             pending;
  logic [31:0]      res_ip;
  logic [TW-1:0]    timer;
  logic             timer_run;
  logic [RW-1:0]    retry_cnt;

  // Message-only parameters and header fields the scheduler never looks at.
  logic unused_inputs;
  assign unused_inputs = (VERBOSE != 0) ^ ($bits(DUT_STRING) == 0) ^
                         (^rx_hdr.proto) ^ (^rx_hdr.dst_mac);

  assign push_req = rx_val && (rx_hdr.oper == OPER_REQ) &&
                    (rx_hdr.dst_ipv4_addr == dev.ipv4_addr);
  assign rx_entry = '{mac_addr: rx_hdr.src_mac, ipv4_addr: rx_hdr.src_ipv4_addr};

  arp_vlg_reply_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (rx_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx.send = (state_q == ST_SEND);
  assign tx.hdr  = hdr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      frame_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      frame_req_q <= frame_req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    frame_req_d = frame_req_q;
    pop         = 1'b0;
    take_req    = 1'b0;
    timer_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          hdr_d       = make_reply_hdr(dev, head);
          frame_req_d = 1'b0;
          state_d     = ST_SEND;
        end else if (pending) begin
          take_req    = 1'b1;
          hdr_d       = make_request_hdr(dev, res_ip);
          frame_req_d = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx.done) begin
          timer_start = frame_req_q;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!tx.done && !tx.busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ovfl <= 1'b0;
    else     ovfl <= push_req && fifo_full && !pop;
  end

  // Later assignments win: res_ok overrides timer expiry and a new frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_busy  <= 1'b0;
      res_fail  <= 1'b0;
      pending   <= 1'b0;
      res_ip    <= '0;
      timer     <= '0;
      timer_run <= 1'b0;
      retry_cnt <= '0;
    end else begin
      res_fail <= 1'b0;
      if (take_req) pending <= 1'b0;
      if (timer_run) begin
        timer <= timer + 1'b1;
        if (timer == TICK_LAST) begin
          timer_run <= 1'b0;
          if (retry_cnt < RETRY_MAX) begin
            retry_cnt <= retry_cnt + 1'b1;
            pending   <= 1'b1;
          end else begin
            res_fail <= 1'b1;
            res_busy <= 1'b0;
          end
        end
      end
      if (timer_start && res_busy) begin
        timer     <= '0;
        timer_run <= 1'b1;
      end
      if (res_req && !res_busy) begin
        res_ip    <= res_ipv4;
        res_busy  <= 1'b1;
        pending   <= 1'b1;
        retry_cnt <= '0;
        timer_run <= 1'b0;
      end
      if (res_ok && res_busy) begin
        res_busy  <= 1'b0;
        res_fail  <= 1'b0;
        pending   <= 1'b0;
        timer     <= '0;
        timer_run <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arp_vlg_tx_ctl.sv
// Directed bench for the ARP transmit scheduler with a hand-driven transmitter.
module tb_arp_vlg_tx_ctl;
  import arp_vlg_tx_ctl_pkg::*;

  logic        clk;
  logic        rst;
  dev_t        dev;
  logic        rx_val;
  arp_hdr_t    rx_hdr;
  logic        res_req;
  logic [31:0] res_ipv4;
  logic        res_ok;
  logic        res_busy;
  logic        res_fail;
  logic        ovfl;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  arp_vlg_tx_ctl_if tx_if ();

  arp_vlg_tx_ctl #(
    .VERBOSE     (0),
    .DUT_STRING  ("tb"),
    .FIFO_DEPTH  (4),
    .RETRY_TICKS (100),
    .RETRIES     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dev      (dev),
    .rx_val   (rx_val),
    .rx_hdr   (rx_hdr),
    .res_req  (res_req),
    .res_ipv4 (res_ipv4),
    .res_ok   (res_ok),
    .tx       (tx_if),
    .res_busy (res_busy),
    .res_fail (res_fail),
    .ovfl     (ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_send(input string tag, input int budget);
    int n = 0;
    while (tx_if.send !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, {63'b0, tx_if.send}, 64'd1);
  endtask

  // Transmitter finishes the frame in WAIT; busy lingers to exercise the GAP hold.
  task automatic complete(input string tag);
    tx_if.done = 1'b1;
    tx_if.busy = 1'b1;
    tick();
    tx_if.done = 1'b0;
    tick();
    tick();
    check(tag, {63'b0, tx_if.send}, 64'd0);
    tx_if.busy = 1'b0;
    tick();
  endtask

  function automatic arp_hdr_t mk_rx(logic [15:0] oper, logic [47:0] smac,
                                     logic [31:0] sip, logic [31:0] dip);
    arp_hdr_t h;
    h               = '0;
    h.oper          = oper;
    h.proto         = 16'h0800;
    h.src_mac       = smac;
    h.src_ipv4_addr = sip;
    h.dst_mac       = 48'h0;
    h.dst_ipv4_addr = dip;
    return h;
  endfunction

  initial begin
    int sends;
    int fails;
    int ovfl_cnt;
    int d_cyc;
    int n;

    rst         = 1'b1;
    dev         = '{mac_addr: 48'h02_00_00_00_00_01, ipv4_addr: 32'hC0A8_010A};
    rx_val      = 1'b0;
    rx_hdr      = '0;
    res_req     = 1'b0;
    res_ipv4    = '0;
    res_ok      = 1'b0;
    tx_if.done  = 1'b0;
    tx_if.busy  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_send", {63'b0, tx_if.send}, 64'd0);
    check("rst_hdr_oper", {48'b0, tx_if.hdr.oper}, 64'd0);
    check("rst_hdr_dmac", {16'b0, tx_if.hdr.dst_mac}, 64'd0);
    check("rst_res_busy", {63'b0, res_busy}, 64'd0);
    check("rst_res_fail", {63'b0, res_fail}, 64'd0);
    check("rst_ovfl", {63'b0, ovfl}, 64'd0);
    rst = 1'b0;
    tick();

    // Matching request -> reply, send at N+2
    rx_hdr = mk_rx(16'd1, 48'h02_00_00_00_00_05, 32'hC0A8_0105, 32'hC0A8_010A);
    rx_val = 1'b1;
    tick();
    rx_val = 1'b0;
    check("rep_lat_n1", {63'b0, tx_if.send}, 64'd0);
    tick();
    check("rep_lat_n2", {63'b0, tx_if.send}, 64'd1);
    check("rep_oper", {48'b0, tx_if.hdr.oper}, 64'd2);
    check("rep_proto", {48'b0, tx_if.hdr.proto}, 64'h0800);
    check("rep_dmac", {16'b0, tx_if.hdr.dst_mac}, 64'h02_00_00_00_00_05);
    check("rep_dip", {32'b0, tx_if.hdr.dst_ipv4_addr}, 64'hC0A8_0105);
    check("rep_smac", {16'b0, tx_if.hdr.src_mac}, 64'h02_00_00_00_00_01);
    check("rep_sip", {32'b0, tx_if.hdr.src_ipv4_addr}, 64'hC0A8_010A);
    tick();
    check("rep_send_1cyc", {63'b0, tx_if.send}, 64'd0);
    complete("rep_gap");

    // Non-matching frames are ignored
    rx_hdr = mk_rx(16'd1, 48'h02_00_00_00_00_07, 32'hC0A8_0107, 32'hC0A8_010B);
    rx_val = 1'b1;
    tick();
    rx_hdr = mk_rx(16'd2, 48'h02_00_00_00_00_07, 32'hC0A8_0107, 32'hC0A8_010A);
    tick();
    rx_val = 1'b0;
    sends = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tx_if.send) sends++;
    end
    check("ignore_nosend", 64'(sends), 64'd0);

    // Overflow: one frame stuck in WAIT, then five replies queued
    rx_hdr = mk_rx(16'd1, 48'h02_00_00_00_00_05, 32'hC0A8_0105, 32'hC0A8_010A);
    rx_val = 1'b1;
    tick();
    rx_val = 1'b0;
    wait_send("ovf_first_send", 4);
    tick();
    tx_if.busy = 1'b1;
    ovfl_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      rx_hdr = mk_rx(16'd1, 48'h02_00_00_00_00_10 + 48'(k), 32'hC0A8_011E + 32'(k), 32'hC0A8_010A);
      rx_val = 1'b1;
      tick();
      if (ovfl) ovfl_cnt++;
    end
    rx_val = 1'b0;
    check("ovfl_on_5th", {63'b0, ovfl}, 64'd1);
    tick();
    check("ovfl_one_cycle", {63'b0, ovfl}, 64'd0);
    check("ovfl_count", 64'(ovfl_cnt), 64'd1);
    complete("ovf_first_gap");
    for (int k = 0; k < 4; k++) begin
      wait_send("ovf_rep_send", 4);
      check("ovf_rep_dip", {32'b0, tx_if.hdr.dst_ipv4_addr}, 64'hC0A8_011E + 64'(k));
      check("ovf_rep_dmac", {16'b0, tx_if.hdr.dst_mac}, 64'h02_00_00_00_00_10 + 64'(k));
      tick();
      complete("ovf_rep_gap");
    end
    sends = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_if.send) sends++;
    end
    check("ovf_only_four", 64'(sends), 64'd0);

    // Request with retries until failure
    res_ipv4 = 32'hC0A8_0114;
    res_req  = 1'b1;
    tick();
    res_req = 1'b0;
    check("req_lat_n1", {63'b0, tx_if.send}, 64'd0);
    check("req_busy", {63'b0, res_busy}, 64'd1);
    tick();
    check("req_lat_n2", {63'b0, tx_if.send}, 64'd1);
    d_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      check("req_oper", {48'b0, tx_if.hdr.oper}, 64'd1);
      check("req_dmac", {16'b0, tx_if.hdr.dst_mac}, 64'hFFFF_FFFF_FFFF);
      check("req_dip", {32'b0, tx_if.hdr.dst_ipv4_addr}, 64'hC0A8_0114);
      if (i > 0) check("req_spacing", 64'(cyc - d_cyc), 64'd102);
      tick();
      tx_if.done = 1'b1;
      d_cyc = cyc;
      tick();
      tx_if.done = 1'b0;
      if (i < 3) wait_send("req_retry_send", 120);
    end
    sends = 0;
    n = 0;
    while (res_fail !== 1'b1 && n < 120) begin
      tick();
      n++;
      if (tx_if.send) sends++;
    end
    check("fail_pulse", {63'b0, res_fail}, 64'd1);
    check("fail_time", 64'(cyc - d_cyc), 64'd101);
    check("fail_busy_clr", {63'b0, res_busy}, 64'd0);
    check("fail_no_5th", 64'(sends), 64'd0);
    tick();
    check("fail_one_cycle", {63'b0, res_fail}, 64'd0);

    // res_ok after first done stops retries
    res_ipv4 = 32'hC0A8_0116;
    res_req  = 1'b1;
    tick();
    res_req = 1'b0;
    wait_send("ok_send", 4);
    tick();
    tx_if.done = 1'b1;
    d_cyc = cyc;
    tick();
    tx_if.done = 1'b0;
    while (cyc < d_cyc + 10) tick();
    res_ok = 1'b1;
    tick();
    res_ok = 1'b0;
    check("ok_busy_clr", {63'b0, res_busy}, 64'd0);
    sends = 0;
    fails = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (tx_if.send) sends++;
      if (res_fail) fails++;
    end
    check("ok_no_retry", 64'(sends), 64'd0);
    check("ok_no_fail", 64'(fails), 64'd0);

    // Reply beats a pending request; rx_val and res_req together
    rx_hdr = mk_rx(16'd1, 48'h02_00_00_00_00_06, 32'hC0A8_0106, 32'hC0A8_010A);
    rx_val = 1'b1;
    tick();
    rx_val = 1'b0;
    wait_send("prio_first_send", 4);
    tick();
    rx_hdr   = mk_rx(16'd1, 48'h02_00_00_00_00_40, 32'hC0A8_0128, 32'hC0A8_010A);
    rx_val   = 1'b1;
    res_ipv4 = 32'hC0A8_0115;
    res_req  = 1'b1;
    tick();
    rx_val  = 1'b0;
    res_req = 1'b0;
    check("prio_req_acc", {63'b0, res_busy}, 64'd1);
    complete("prio_first_gap");
    wait_send("prio_rep_send", 4);
    check("prio_rep_oper", {48'b0, tx_if.hdr.oper}, 64'd2);
    check("prio_rep_dip", {32'b0, tx_if.hdr.dst_ipv4_addr}, 64'hC0A8_0128);
    tick();
    complete("prio_rep_gap");
    wait_send("prio_req_send", 4);
    check("prio_req_oper", {48'b0, tx_if.hdr.oper}, 64'd1);
    check("prio_req_dip", {32'b0, tx_if.hdr.dst_ipv4_addr}, 64'hC0A8_0115);
    tick();

    // Reset mid-WAIT with a reply queued
    rx_hdr = mk_rx(16'd1, 48'h02_00_00_00_00_41, 32'hC0A8_0129, 32'hC0A8_010A);
    rx_val = 1'b1;
    tick();
    rx_val = 1'b0;
    rst    = 1'b1;
    tick();
    check("mrst_send", {63'b0, tx_if.send}, 64'd0);
    check("mrst_hdr_oper", {48'b0, tx_if.hdr.oper}, 64'd0);
    check("mrst_hdr_dip", {32'b0, tx_if.hdr.dst_ipv4_addr}, 64'd0);
    check("mrst_res_busy", {63'b0, res_busy}, 64'd0);
    check("mrst_res_fail", {63'b0, res_fail}, 64'd0);
    check("mrst_ovfl", {63'b0, ovfl}, 64'd0);
    rst = 1'b0;
    sends = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_if.send) sends++;
    end
    check("mrst_no_send", 64'(sends), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
